// File: rtl/led_frame_recv.sv
//------------------------------------------------------------------------------
// Module   : led_frame_recv
// Brief    : LED serial link receiver; decodes start/LED/end frames from cki/sdi.
//            Optional statistics counters enabled by LED_FRAME_RECV_STAT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_frame_recv #(
    parameter int LED_NUM     = 4,
    parameter int TIMEOUT_CNT = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cki,
    input  logic        sdi,
    output logic        pix_valid,
    output logic [9:0]  pix_idx,
    output logic [4:0]  pix_bright,
    output logic [23:0] pix_bgr,
    output logic        frame_done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [9:0]  c_led_num = 10'(LED_NUM);
    localparam logic [15:0] c_timeout = 16'(TIMEOUT_CNT);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_DATA = 2'd1,
        ST_END  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_cki_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_cki_d;
    logic [30:0]            r_shift;
    logic [15:0]            r_idle_cnt;
    logic [4:0]             r_zero_cnt;
    logic [4:0]             r_bit_cnt;
    logic [9:0]             r_led_cnt;

    logic        r_pix_valid, r_frame_done, r_err;
    logic [9:0]  r_pix_idx;
    logic [4:0]  r_pix_bright;
    logic [23:0] r_pix_bgr;
    logic [1:0]  r_err_code;

    logic        w_rise, w_sdi, w_idle;
    logic [31:0] w_word;
    logic        w_pix_fire, w_done_fire, w_err_fire;
    logic [1:0]  w_err_code_nxt;

    assign w_rise = r_cki_sync[SYNC_STAGES-1] & ~r_cki_d;
    assign w_sdi  = r_sdi_sync[SYNC_STAGES-1];
    assign w_idle = (r_idle_cnt == c_timeout);
    // Last bit is taken straight from the synchronizer so the word is judged in its rise cycle.
    assign w_word = {r_shift, w_sdi};

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_HUNT;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pix_fire     = 1'b0;
        w_done_fire    = 1'b0;
        w_err_fire     = 1'b0;
        w_err_code_nxt = r_err_code;
        case (r_state)
            ST_HUNT: begin
                if (w_rise && !w_sdi && r_zero_cnt == 5'd31)
                    w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (w_rise) begin
                    if (r_bit_cnt == 5'd31) begin
                        if (w_word == 32'h0 && r_led_cnt == 10'd0) begin
                            w_state_nxt = ST_DATA;
                        end else if (r_led_cnt < c_led_num) begin
                            if (w_word[31:29] == 3'b111) begin
                                w_pix_fire = 1'b1;
                            end else begin
                                w_err_fire     = 1'b1;
                                w_err_code_nxt = 2'd1;
                                w_state_nxt    = ST_HUNT;
                            end
                        end else if (w_word == 32'hFFFF_FFFF) begin
                            w_done_fire = 1'b1;
                            w_state_nxt = ST_END;
                        end else begin
                            w_err_fire     = 1'b1;
                            w_err_code_nxt = 2'd2;
                            w_state_nxt    = ST_HUNT;
                        end
                    end
                end else if (w_idle) begin
                    w_err_fire     = 1'b1;
                    w_err_code_nxt = 2'd3;
                    w_state_nxt    = ST_HUNT;
                end
            end
            ST_END: begin
                if (!w_rise && w_idle)
                    w_state_nxt = ST_HUNT;
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cki_sync   <= '0;
            r_sdi_sync   <= '0;
            r_cki_d      <= 1'b0;
            r_shift      <= '0;
            r_idle_cnt   <= '0;
            r_zero_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_led_cnt    <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_idx    <= '0;
            r_pix_bright <= '0;
            r_pix_bgr    <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
        end else begin
            r_cki_sync <= {r_cki_sync[SYNC_STAGES-2:0], cki};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
            r_cki_d    <= r_cki_sync[SYNC_STAGES-1];

            if (w_rise)
                r_shift <= w_word[30:0];

            if (w_rise)
                r_idle_cnt <= '0;
            else if (!w_idle)
                r_idle_cnt <= r_idle_cnt + 16'd1;

            if (r_state != ST_HUNT || w_state_nxt != ST_HUNT)
                r_zero_cnt <= '0;
            else if (w_rise)
                r_zero_cnt <= w_sdi ? 5'd0 : r_zero_cnt + 5'd1;

            if (r_state != ST_DATA)
                r_bit_cnt <= '0;
            else if (w_rise)
                r_bit_cnt <= r_bit_cnt + 5'd1;

            if (r_state != ST_DATA)
                r_led_cnt <= '0;
            else if (w_pix_fire)
                r_led_cnt <= r_led_cnt + 10'd1;

            r_pix_valid  <= w_pix_fire;
            r_frame_done <= w_done_fire;
            r_err        <= w_err_fire;
            r_err_code   <= w_err_code_nxt;
            if (w_pix_fire) begin
                r_pix_idx    <= r_led_cnt;
                r_pix_bright <= w_word[28:24];
                r_pix_bgr    <= w_word[23:0];
            end
        end
    end

    assign pix_valid  = r_pix_valid;
    assign pix_idx    = r_pix_idx;
    assign pix_bright = r_pix_bright;
    assign pix_bgr    = r_pix_bgr;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign busy       = (r_state != ST_HUNT);

`ifdef LED_FRAME_RECV_STAT_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_frame_done && r_frame_cnt != 16'hFFFF)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            if (r_err && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_frame_recv.sv
//------------------------------------------------------------------------------
// Module   : tb_led_frame_recv
// Brief    : Directed, table-driven self-checking bench for led_frame_recv.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_frame_recv;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cki = 1'b0;
    logic        sdi = 1'b0;
    logic        pix_valid;
    logic [9:0]  pix_idx;
    logic [4:0]  pix_bright;
    logic [23:0] pix_bgr;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    led_frame_recv #(.LED_NUM(4), .TIMEOUT_CNT(T), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .cki(cki), .sdi(sdi),
        .pix_valid(pix_valid), .pix_idx(pix_idx), .pix_bright(pix_bright),
        .pix_bgr(pix_bgr), .frame_done(frame_done), .err(err),
        .err_code(err_code), .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [4:0]  bright;
        logic [23:0] bgr;
    } vec_t;

    typedef struct packed {
        logic [9:0]  idx;
        logic [4:0]  bright;
        logic [23:0] bgr;
    } pix_t;

    vec_t vt[8];
    pix_t pix_q[$];
    int   err_q[$];
    int   err_cyc      = 0;
    int   n_done       = 0;
    int   excl_viol    = 0;
    int   rst_strobes  = 0;
    int   cyc          = 0;
    int   last_rise    = 0;
    int   n_vec        = 0;
    int   n_bad        = 0;
    int   mon_n;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe capture, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        mon_n = int'(pix_valid) + int'(frame_done) + int'(err);
        if (mon_n > 1) excl_viol++;
        if (rst && mon_n != 0) rst_strobes++;
        if (pix_valid) pix_q.push_back({pix_idx, pix_bright, pix_bgr});
        if (frame_done) n_done++;
        if (err) begin
            err_q.push_back(int'(err_code));
            err_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        cki = 1'b0;
        sdi = b;
        repeat (3) @(negedge clk);
        cki = 1'b1;
        last_rise = cyc;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic go_idle();
        repeat (T + 16) @(negedge clk);
    endtask

    task automatic clear_mon();
        pix_q.delete();
        err_q.delete();
        n_done = 0;
    endtask

    task automatic send_packet(input int base, input int lead_zeros);
        send_zeros(lead_zeros);
        for (int i = 0; i < 4; i++) send_word(vt[base + i].word);
        send_word(32'hFFFF_FFFF);
    endtask

    task automatic check_pixels(input int base, input string tag);
        pix_t got;
        check({tag, "_npix"}, 64'(pix_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < pix_q.size()) ? pix_q[i] : '0;
            check({tag, "_pix"}, 64'(got), 64'({10'(i), vt[base + i].bright, vt[base + i].bgr}));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'hE100_00FF, 5'd1,  24'h0000FF};
        vt[1] = '{32'hFF00_FF00, 5'd31, 24'h00FF00};
        vt[2] = '{32'hFFFF_0000, 5'd31, 24'hFF0000};
        vt[3] = '{32'hFFFF_FFFF, 5'd31, 24'hFFFFFF};
        vt[4] = '{32'hE512_3456, 5'd5,  24'h123456};
        vt[5] = '{32'hFFAB_CDEF, 5'd31, 24'hABCDEF};
        vt[6] = '{32'hE000_0000, 5'd0,  24'h000000};
        vt[7] = '{32'hFFFF_FFFF, 5'd31, 24'hFFFFFF};

        // Reset values
        repeat (4) @(negedge clk);
        check("rst_pix_valid",  64'(pix_valid),  64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_err",        64'(err),        64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_err_code",   64'(err_code),   64'd0);
        check("rst_pix_fields", 64'({pix_idx, pix_bright, pix_bgr}), 64'd0);
        check("rst_counters",   64'({frame_cnt, err_cnt}), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Nominal packet, then busy drops one timeout after the last edge
        clear_mon();
        send_packet(0, 32);
        check_pixels(0, "nominal");
        check("nominal_done", 64'(n_done), 64'd1);
        check("nominal_nerr", 64'(err_q.size()), 64'd0);
        while (cyc < last_rise + T - 1) @(negedge clk);
        check("end_busy_high", 64'(busy), 64'd1);
        while (cyc < last_rise + T + 6) @(negedge clk);
        check("end_busy_low", 64'(busy), 64'd0);
        go_idle();

        // Extended start frame, all-ones pixel word
        clear_mon();
        send_packet(4, 64);
        go_idle();
        check_pixels(4, "longstart");
        check("longstart_done", 64'(n_done), 64'd1);
        check("longstart_nerr", 64'(err_q.size()), 64'd0);

        // Bad header on second LED word, then recovery
        clear_mon();
        send_zeros(32);
        send_word(32'hE100_00FF);
        send_word(32'h7F12_3456);
        send_word(32'hFFFF_0000);
        send_word(32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF);
        go_idle();
        check("badhdr_npix", 64'(pix_q.size()), 64'd1);
        check("badhdr_nerr", 64'(err_q.size()), 64'd1);
        check("badhdr_code", 64'(err_q.size() > 0 ? err_q[0] : 0), 64'd1);
        check("badhdr_done", 64'(n_done), 64'd0);
        check("badhdr_code_held", 64'(err_code), 64'd1);
        clear_mon();
        send_packet(0, 32);
        go_idle();
        check_pixels(0, "recover");
        check("recover_done", 64'(n_done), 64'd1);
        check("recover_nerr", 64'(err_q.size()), 64'd0);

        // Missing end frame
        clear_mon();
        send_zeros(32);
        for (int i = 0; i < 4; i++) send_word(vt[i].word);
        send_word(32'hE000_0000);
        go_idle();
        check("noend_npix", 64'(pix_q.size()), 64'd4);
        check("noend_nerr", 64'(err_q.size()), 64'd1);
        check("noend_code", 64'(err_q.size() > 0 ? err_q[0] : 0), 64'd2);
        check("noend_done", 64'(n_done), 64'd0);

        // Line clock stops after 40 bits; allow for the synchronizer latency
        clear_mon();
        send_zeros(32);
        for (int i = 7; i >= 0; i--) send_bit(vt[0].word[24 + i]);
        go_idle();
        check("timeout_nerr", 64'(err_q.size()), 64'd1);
        check("timeout_code", 64'(err_q.size() > 0 ? err_q[0] : 0), 64'd3);
        check("timeout_lat_window",
              64'((err_cyc - last_rise >= T) && (err_cyc - last_rise <= T + 6)), 64'd1);
        check("timeout_busy", 64'(busy), 64'd0);

        // Packet, reset mid-word, then three packets
        clear_mon();
        send_packet(4, 32);
        go_idle();
        check("b2b_first_done", 64'(n_done), 64'd1);
        send_zeros(32);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        for (int p = 0; p < 3; p++) begin
            send_packet(0, 32);
            go_idle();
        end
        check("b2b_done", 64'(n_done), 64'd3);
        check("b2b_npix", 64'(pix_q.size()), 64'd12);
        check("b2b_nerr", 64'(err_q.size()), 64'd0);
        check("rst_no_strobe", 64'(rst_strobes), 64'd0);
`ifdef LED_FRAME_RECV_STAT_EN
        check("stat_frame_cnt", 64'(frame_cnt), 64'd3);
`else
        check("stat_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
        check("stat_err_cnt", 64'(err_cnt), 64'd0);
        check("strobe_exclusive", 64'(excl_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
